// File: rtl/ibex_rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NumReq writeback sources,
// with a one-entry registered output stage, x0/RV32E drop handling and a pending-write mask.
module ibex_rf_wb_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*5-1:0]         req_addr_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    input  logic                        wb_stall_i,
    output logic [4:0]                  waddr_a_o,
    output logic [DataWidth-1:0]        wdata_a_o,
    output logic                        we_a_o,
    output logic [31:0]                 pending_o,
    output logic                        err_o,
    output logic                        busy_o
);

    localparam int unsigned PtrW   = 2;
    localparam int unsigned MaxReq = 4;

    logic [PtrW-1:0]                      rr_ptr;
    logic [PtrW-1:0]                      rr_ptr_nxt;
    logic                                 out_valid;
    logic [4:0]                           out_addr;
    logic [DataWidth-1:0]                 out_data;
    logic                                 err_q;

    logic                                 can_accept;
    logic                                 gnt_found;
    logic                                 xfer;
    logic [PtrW-1:0]                      gnt_idx;
    logic [4:0]                           gnt_addr;
    logic [DataWidth-1:0]                 gnt_data;

    logic [MaxReq-1:0]                    valid_pad;
    logic [MaxReq-1:0][4:0]               addr_arr;
    logic [MaxReq-1:0][DataWidth-1:0]     data_arr;

    // Requesters are padded out to four lanes so the scan below can use a fixed-width index.
    for (genvar k = 0; k < MaxReq; k++) begin : g_lane
        if (k < NumReq) begin : g_used
            assign valid_pad[k] = req_valid_i[k];
            assign addr_arr[k]  = req_addr_i[5*k +: 5];
            assign data_arr[k]  = req_data_i[DataWidth*k +: DataWidth];
        end else begin : g_unused
            assign valid_pad[k] = 1'b0;
            assign addr_arr[k]  = '0;
            assign data_arr[k]  = '0;
        end
    end

    assign can_accept = ~out_valid | ~wb_stall_i;

    always_comb begin
        int unsigned idx;
        idx        = 0;
        gnt_found  = 1'b0;
        gnt_idx    = '0;
        gnt_addr   = '0;
        gnt_data   = '0;
        rr_ptr_nxt = rr_ptr;
        for (int unsigned off = 0; off < NumReq; off++) begin
            idx = (32'(rr_ptr) + off) % NumReq;
            if (!gnt_found && valid_pad[idx[PtrW-1:0]]) begin
                gnt_found  = 1'b1;
                gnt_idx    = idx[PtrW-1:0];
                gnt_addr   = addr_arr[idx[PtrW-1:0]];
                gnt_data   = data_arr[idx[PtrW-1:0]];
                rr_ptr_nxt = (idx == NumReq - 1) ? '0 : idx[PtrW-1:0] + 2'd1;
            end
        end
    end

    assign xfer = gnt_found & can_accept & ~rst_i;

    for (genvar k = 0; k < NumReq; k++) begin : g_ready
        assign req_ready_o[k] = xfer & (gnt_idx == PtrW'(k));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (xfer) begin
                rr_ptr <= rr_ptr_nxt;
                if (gnt_addr == 5'd0) begin
                    out_valid <= 1'b0;
                end else if (RV32E && gnt_addr[4]) begin
                    out_valid <= 1'b0;
                    err_q     <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_addr  <= gnt_addr;
                    out_data  <= gnt_data;
                end
            end else if (can_accept) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        if (out_valid) begin
            pending_o[out_addr] = 1'b1;
        end
    end

    // Write enable is masked during reset so a held write is discarded rather than committed at the reset edge.
    assign we_a_o    = out_valid & ~wb_stall_i & ~rst_i;
    assign waddr_a_o = out_addr;
    assign wdata_a_o = out_data;
    assign err_o     = err_q;
    assign busy_o    = out_valid;

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Bench for ibex_rf_wb_arbiter: a 3-requester RV32E instance against a cycle model and write
// scoreboard, plus a 2-requester RV32I instance checked against fixed expectations.
module tb_ibex_rf_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [14:0] addr;
    logic [95:0] data;
    logic        stall;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] pending;
    logic        err;
    logic        busy;

    logic        b_rst;
    logic [1:0]  b_valid;
    logic [1:0]  b_ready;
    logic [9:0]  b_addr;
    logic [63:0] b_data;
    logic        b_stall;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_we;
    logic [31:0] b_pending;
    logic        b_err;
    logic        b_busy;

    ibex_rf_wb_arbiter #(.NumReq(3), .RV32E(1'b1), .DataWidth(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
        .req_addr_i(addr), .req_data_i(data), .wb_stall_i(stall),
        .waddr_a_o(waddr), .wdata_a_o(wdata), .we_a_o(we),
        .pending_o(pending), .err_o(err), .busy_o(busy)
    );

    ibex_rf_wb_arbiter #(.NumReq(2), .RV32E(1'b0), .DataWidth(32)) u_dut_i (
        .clk_i(clk), .rst_i(b_rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_addr_i(b_addr), .req_data_i(b_data), .wb_stall_i(b_stall),
        .waddr_a_o(b_waddr), .wdata_a_o(b_wdata), .we_a_o(b_we),
        .pending_o(b_pending), .err_o(b_err), .busy_o(b_busy)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  m_ptr    = 0;
    bit  m_ov     = 1'b0;
    bit  m_err    = 1'b0;
    int  n_we     = 0;
    int  n_acc    = 0;

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        r = '0;
        if (rst === 1'b1) return r;
        if (m_ov && stall) return r;
        for (int o = 0; o < 3; o++) begin
            int i;
            i = (m_ptr + o) % 3;
            if (valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Applies this cycle's clock edge to the model, then moves to the next falling edge.
    task automatic advance();
        logic [2:0]  g;
        bit          can;
        logic [4:0]  a;
        logic [31:0] d;
        wr_t         w;
        g     = exp_ready();
        can   = !m_ov || !stall;
        m_err = 1'b0;
        if (rst) begin
            m_ptr = 0;
            m_ov  = 1'b0;
            exp_q.delete();
        end else if (g != 3'b000) begin
            for (int i = 0; i < 3; i++) begin
                if (g[i]) begin
                    m_ptr = (i + 1) % 3;
                    a = addr[5*i +: 5];
                    d = data[32*i +: 32];
                    if (a == 5'd0) begin
                        m_ov = 1'b0;
                    end else if (a[4]) begin
                        m_ov  = 1'b0;
                        m_err = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                        w.a  = a;
                        w.d  = d;
                        exp_q.push_back(w);
                        n_acc++;
                    end
                end
            end
        end else if (can) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = '0;
        stall = 1'b0;
        #1;
        advance();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        wr_t w;
        #3;
        if (we === 1'b1) begin
            n_we++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_write: got write addr=%0d data=%h, required no write", waddr, wdata);
            end else begin
                w = exp_q.pop_front();
                if (waddr !== w.a || wdata !== w.d)
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h", waddr, wdata, w.a, w.d);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst   = 1'b1;
        valid = 3'b111;
        addr  = {5'd3, 5'd2, 5'd1};
        #1;
        n_checks++;
        if (ready !== 3'b000) $display("FAIL reset_ready: got %b, required 000", ready); else n_pass++;
        advance();
        advance();
        rst   = 1'b0;
        valid = '0;
        #1;
        n_checks++;
        if ({busy, we, err} !== 3'b000) $display("FAIL reset_flags: got busy/we/err=%b, required 000", {busy, we, err}); else n_pass++;
        n_checks++;
        if (pending !== 32'h0) $display("FAIL reset_pending: got %h, required 0", pending); else n_pass++;
        n_checks++;
        if (waddr !== 5'd0 || wdata !== 32'h0) $display("FAIL reset_wport: got addr=%0d data=%h, required 0/0", waddr, wdata); else n_pass++;
        advance();
    endtask

    task automatic test_single();
        do_reset();
        valid = 3'b001;
        addr  = {5'd0, 5'd0, 5'd5};
        data  = {64'h0, 32'hDEADBEEF};
        #1;
        n_checks++;
        if (ready !== 3'b001) $display("FAIL single_ready: got %b, required 001", ready); else n_pass++;
        advance();
        valid = '0;
        #1;
        n_checks++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF)
            $display("FAIL single_write: got we=%b addr=%0d data=%h, required 1/5/deadbeef", we, waddr, wdata);
        else n_pass++;
        n_checks++;
        if (pending !== 32'h20) $display("FAIL single_pending: got %h, required 00000020", pending); else n_pass++;
        advance();
        #1;
        n_checks++;
        if (we !== 1'b0) $display("FAIL single_we_clear: got %b, required 0", we); else n_pass++;
        advance();
    endtask

    task automatic test_round_robin();
        do_reset();
        valid = 3'b011;
        addr  = {5'd0, 5'd2, 5'd1};
        data  = {32'h0, 32'h2222_0002, 32'h1111_0001};
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (ready !== ((i % 2 == 0) ? 3'b001 : 3'b010))
                $display("FAIL rr_grant[%0d]: got %b, required %b", i, ready, (i % 2 == 0) ? 3'b001 : 3'b010);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (we !== 1'b1) $display("FAIL rr_we[%0d]: got %b, required 1", i, we); else n_pass++;
            end
            advance();
        end
        valid = '0;
        #1;
        n_checks++;
        if (we !== 1'b1 || waddr !== 5'd2) $display("FAIL rr_last: got we=%b addr=%0d, required 1/2", we, waddr); else n_pass++;
        advance();
    endtask

    task automatic test_stall();
        do_reset();
        valid = 3'b001;
        addr  = {5'd0, 5'd0, 5'd7};
        data  = {32'h0, 32'h0, 32'h7777_7777};
        #1;
        advance();
        valid = 3'b010;
        addr  = {5'd0, 5'd3, 5'd7};
        data  = {32'h0, 32'h3333_3333, 32'h7777_7777};
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (we !== 1'b0 || ready !== 3'b000)
                $display("FAIL stall_block[%0d]: got we=%b ready=%b, required 0/000", i, we, ready);
            else n_pass++;
            n_checks++;
            if (pending !== 32'h80 || busy !== 1'b1)
                $display("FAIL stall_hold[%0d]: got pending=%h busy=%b, required 00000080/1", i, pending, busy);
            else n_pass++;
            advance();
        end
        stall = 1'b0;
        #1;
        n_checks++;
        if (we !== 1'b1 || waddr !== 5'd7) $display("FAIL stall_release: got we=%b addr=%0d, required 1/7", we, waddr); else n_pass++;
        n_checks++;
        if (ready !== 3'b010) $display("FAIL stall_refill: got %b, required 010", ready); else n_pass++;
        advance();
        valid = '0;
        #1;
        n_checks++;
        if (we !== 1'b1 || waddr !== 5'd3) $display("FAIL stall_next: got we=%b addr=%0d, required 1/3", we, waddr); else n_pass++;
        advance();
    endtask

    task automatic test_drops();
        do_reset();
        valid = 3'b001;
        addr  = {5'd0, 5'd0, 5'd0};
        data  = {64'h0, 32'hAAAA_AAAA};
        #1;
        n_checks++;
        if (ready !== 3'b001) $display("FAIL x0_ready: got %b, required 001", ready); else n_pass++;
        advance();
        valid = '0;
        #1;
        n_checks++;
        if ({we, err, busy} !== 3'b000) $display("FAIL x0_drop: got we/err/busy=%b, required 000", {we, err, busy}); else n_pass++;
        advance();
        valid = 3'b001;
        addr  = {5'd0, 5'd0, 5'd17};
        #1;
        n_checks++;
        if (ready !== 3'b001) $display("FAIL e_ready: got %b, required 001", ready); else n_pass++;
        advance();
        valid = '0;
        #1;
        n_checks++;
        if (err !== 1'b1 || we !== 1'b0) $display("FAIL e_drop: got err=%b we=%b, required 1/0", err, we); else n_pass++;
        advance();
        #1;
        n_checks++;
        if (err !== 1'b0) $display("FAIL e_pulse: got err=%b, required 0", err); else n_pass++;
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 3'b011;
        addr  = {5'd0, 5'd4, 5'd9};
        data  = {32'h0, 32'h4444_4444, 32'h9999_9999};
        #1;
        n_checks++;
        if (ready !== 3'b001) $display("FAIL rm_first: got %b, required 001", ready); else n_pass++;
        advance();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ready !== 3'b000 || we !== 1'b0) $display("FAIL rm_in_reset: got ready=%b we=%b, required 000/0", ready, we); else n_pass++;
        n_checks++;
        if (pending !== 32'h200) $display("FAIL rm_held: got %h, required 00000200", pending); else n_pass++;
        advance();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({we, busy} !== 2'b00 || pending !== 32'h0)
            $display("FAIL rm_cleared: got we/busy=%b pending=%h, required 00/0", {we, busy}, pending);
        else n_pass++;
        n_checks++;
        if (ready !== 3'b001) $display("FAIL rm_ptr: got %b, required 001", ready); else n_pass++;
        advance();
        valid = '0;
        #1;
        advance();
        advance();
    endtask

    task automatic test_fairness();
        int         wait_c[3];
        int         worst;
        logic [2:0] g;
        bit         can;
        do_reset();
        n_we  = 0;
        n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            wait_c[k]        = 0;
            addr[5*k +: 5]   = 5'($urandom_range(0, 20));
            data[32*k +: 32] = $urandom;
        end
        valid = 3'b111;
        for (int c = 0; c < 80; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            #1;
            n_checks++;
            if (ready !== exp_ready()) $display("FAIL fair_ready[%0d]: got %b, required %b", c, ready, exp_ready()); else n_pass++;
            n_checks++;
            if (err !== m_err) $display("FAIL fair_err[%0d]: got %b, required %b", c, err, m_err); else n_pass++;
            g   = ready;
            can = !m_ov || !stall;
            if (can) begin
                worst = 0;
                for (int k = 0; k < 3; k++) begin
                    if (g[k]) wait_c[k] = 0;
                    else wait_c[k]++;
                    if (wait_c[k] > worst) worst = wait_c[k];
                end
                n_checks++;
                if (worst >= 3) $display("FAIL fair_starve[%0d]: got wait=%0d, required below 3", c, worst); else n_pass++;
            end
            advance();
            for (int k = 0; k < 3; k++) begin
                if (g[k]) begin
                    addr[5*k +: 5]   = 5'($urandom_range(0, 20));
                    data[32*k +: 32] = $urandom;
                end
            end
        end
        valid = '0;
        stall = 1'b0;
        #1;
        advance();
        advance();
        #1;
        n_checks++;
        if (n_we !== n_acc) $display("FAIL fair_count: got %0d writes, required %0d", n_we, n_acc); else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL fair_drain: got %0d outstanding, required 0", exp_q.size()); else n_pass++;
        advance();
    endtask

    task automatic test_rv32i();
        rst = 1'b1;
        #1;
        advance();
        b_rst = 1'b1;
        @(negedge clk);
        b_rst   = 1'b0;
        b_valid = 2'b11;
        b_addr  = {5'd0, 5'd17};
        b_data  = {32'h0000_0BAD, 32'h1717_1717};
        #1;
        n_checks++;
        if (b_ready !== 2'b01) $display("FAIL i_first: got %b, required 01", b_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (b_we !== 1'b1 || b_waddr !== 5'd17 || b_wdata !== 32'h1717_1717 || b_err !== 1'b0)
            $display("FAIL i_addr17: got we=%b addr=%0d data=%h err=%b, required 1/17/17171717/0", b_we, b_waddr, b_wdata, b_err);
        else n_pass++;
        n_checks++;
        if (b_ready !== 2'b10) $display("FAIL i_second: got %b, required 10", b_ready); else n_pass++;
        @(negedge clk);
        b_valid = '0;
        #1;
        n_checks++;
        if ({b_we, b_err, b_busy} !== 3'b000 || b_pending !== 32'h0)
            $display("FAIL i_x0: got we/err/busy=%b pending=%h, required 000/0", {b_we, b_err, b_busy}, b_pending);
        else n_pass++;
        b_valid = 2'b11;
        b_addr  = {5'd3, 5'd16};
        #1;
        n_checks++;
        if (b_ready !== 2'b01) $display("FAIL i_wrap: got %b, required 01", b_ready); else n_pass++;
        @(negedge clk);
        b_valid = '0;
        #1;
        n_checks++;
        if (b_we !== 1'b1 || b_waddr !== 5'd16) $display("FAIL i_addr16: got we=%b addr=%0d, required 1/16", b_we, b_waddr); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        valid   = '0;
        addr    = '0;
        data    = '0;
        stall   = 1'b0;
        b_rst   = 1'b1;
        b_valid = '0;
        b_addr  = '0;
        b_data  = '0;
        b_stall = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_drops();
        test_reset_mid();
        test_fairness();
        test_rv32i();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
